// File: rtl/segasys1_vtiming.sv
`timescale 1ns/1ps
// segasys1_vtiming
// Master video timing generator for the System 1 video path. Produces the
// PH/PV raster counters, horizontal/vertical blanking and sync, an 8-bit
// frame counter and the vblank CPU interrupt request (held until INTACK).
// Every output is a register; counters and derived outputs advance only on
// VCLK edges where the pixel enable PCE is high.
//
// Optional build macro: SYS1_VTIMING_OFFSET_EN
//   defined   - HOFS/VOFS are latched once per frame (at the raster wrap)
//               and shift the HSYNC/VSYNC windows by -8..+7 pixels/lines.
//   undefined - HOFS/VOFS are ignored; sync starts exactly at HS_START/VS_START.
//
// Ports:
//   VCLK    in   1  clock, rising edge
//   RESET   in   1  synchronous reset, active-high, highest priority
//   PCE     in   1  pixel clock enable
//   INTACK  in   1  CPU interrupt acknowledge pulse (clears IRQ)
//   HOFS    in   4  signed HSYNC offset
//   VOFS    in   4  signed VSYNC offset
//   PH      out  9  horizontal pixel counter
//   PV      out  9  vertical line counter
//   HBLK    out  1  horizontal blank
//   VBLK    out  1  vertical blank
//   HSYNC   out  1  horizontal sync, active-high
//   VSYNC   out  1  vertical sync, active-high
//   IRQ     out  1  vblank interrupt request, level
//   FRAME   out  8  frame counter

module segasys1_vtiming #(
  parameter int H_TOTAL  = 320,
  parameter int H_ACTIVE = 256,
  parameter int HS_START = 280,
  parameter int HS_WIDTH = 24,
  parameter int V_TOTAL  = 260,
  parameter int V_ACTIVE = 224,
  parameter int VS_START = 236,
  parameter int VS_WIDTH = 3
) (
  input  logic       VCLK,
  input  logic       RESET,
  input  logic       PCE,
  input  logic       INTACK,
  input  logic [3:0] HOFS,
  input  logic [3:0] VOFS,
  output logic [8:0] PH,
  output logic [8:0] PV,
  output logic       HBLK,
  output logic       VBLK,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       IRQ,
  output logic [7:0] FRAME
);

  localparam logic [8:0] H_LAST   = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
  localparam logic [8:0] H_ACT    = 9'(H_ACTIVE);
  localparam logic [8:0] V_ACT    = 9'(V_ACTIVE);
  localparam logic [8:0] V_ACT_P1 = 9'(V_ACTIVE + 1);

  logic       h_wrap;
  logic       v_wrap;
  logic [8:0] ph_nxt;
  logic [8:0] pv_nxt;
  logic [7:0] frame_nxt;

  logic signed [3:0] hofs_nxt;
  logic signed [3:0] vofs_nxt;

  // True when pos lies in the sync window [start+ofs, start+ofs+width),
  // with the window start and the distance taken modulo total so that a
  // window crossing the counter wrap stays contiguous.
  function automatic logic in_window(input logic [8:0] pos,
                                     input logic signed [3:0] ofs,
                                     input int total,
                                     input int start,
                                     input int width);
    int s;
    int d;
    s = start + int'(ofs);
    if (s < 0)
      s = s + total;
    else if (s >= total)
      s = s - total;
    d = int'(pos) - s;
    if (d < 0)
      d = d + total;
    return (d < width);
  endfunction

  always_comb begin
    h_wrap    = (PH == H_LAST);
    v_wrap    = (PV == V_LAST);
    ph_nxt    = h_wrap ? 9'd0 : PH + 9'd1;
    pv_nxt    = PV;
    frame_nxt = FRAME;
    if (h_wrap) begin
      if (v_wrap) begin
        pv_nxt    = 9'd0;
        frame_nxt = FRAME + 8'd1;
      end else begin
        pv_nxt = PV + 9'd1;
      end
    end
  end

`ifdef SYS1_VTIMING_OFFSET_EN
  logic signed [3:0] hofs_l;
  logic signed [3:0] vofs_l;

  // New offsets are used already for the first pixel of the new frame, so
  // the sync outputs registered on the wrap edge match the frame they start.
  always_comb begin
    hofs_nxt = hofs_l;
    vofs_nxt = vofs_l;
    if (h_wrap && v_wrap) begin
      hofs_nxt = HOFS;
      vofs_nxt = VOFS;
    end
  end
`else
  assign hofs_nxt = 4'sd0;
  assign vofs_nxt = 4'sd0;
  logic unused_ofs;
  assign unused_ofs = ^{HOFS, VOFS};
`endif

  always_ff @(posedge VCLK) begin
    if (RESET) begin
      PH    <= 9'd0;
      PV    <= 9'd0;
      FRAME <= 8'd0;
      HBLK  <= 1'b0;
      VBLK  <= 1'b0;
      HSYNC <= 1'b0;
      VSYNC <= 1'b0;
      IRQ   <= 1'b0;
`ifdef SYS1_VTIMING_OFFSET_EN
      hofs_l <= 4'sd0;
      vofs_l <= 4'sd0;
`endif
    end else begin
      if (PCE) begin
        PH    <= ph_nxt;
        PV    <= pv_nxt;
        FRAME <= frame_nxt;
        HBLK  <= (ph_nxt >= H_ACT);
        VBLK  <= (pv_nxt >= V_ACT);
        HSYNC <= in_window(ph_nxt, hofs_nxt, H_TOTAL, HS_START, HS_WIDTH);
        VSYNC <= in_window(pv_nxt, vofs_nxt, V_TOTAL, VS_START, VS_WIDTH);
`ifdef SYS1_VTIMING_OFFSET_EN
        hofs_l <= hofs_nxt;
        vofs_l <= vofs_nxt;
`endif
      end

      // Setting on the vblank line entry beats a simultaneous acknowledge.
      if (PCE && ph_nxt == 9'd0 && pv_nxt == V_ACT)
        IRQ <= 1'b1;
      else if (INTACK || (PCE && ph_nxt == 9'd0 && pv_nxt == V_ACT_P1))
        IRQ <= 1'b0;
    end
  end

endmodule

// File: tb/tb_segasys1_vtiming.sv
`timescale 1ns/1ps
module tb_segasys1_vtiming;

`ifdef SYS1_VTIMING_OFFSET_EN
  localparam bit OFS_EN = 1'b1;
`else
  localparam bit OFS_EN = 1'b0;
`endif

  logic VCLK = 1'b0;
  always #5 VCLK = ~VCLK;

  // default-parameter instance
  logic       rst0, pce0, ack0;
  logic [3:0] hofs0, vofs0;
  logic [8:0] ph0, pv0;
  logic       hblk0, vblk0, hs0, vs0, irq0;
  logic [7:0] frame0;

  // short-frame instance with HSYNC close to the line wrap
  logic       rst1, pce1, ack1;
  logic [3:0] hofs1, vofs1;
  logic [8:0] ph1, pv1;
  logic       hblk1, vblk1, hs1, vs1, irq1;
  logic [7:0] frame1;

  int n_cmp = 0;
  int n_mis = 0;

  segasys1_vtiming u_dut0 (
    .VCLK(VCLK), .RESET(rst0), .PCE(pce0), .INTACK(ack0),
    .HOFS(hofs0), .VOFS(vofs0),
    .PH(ph0), .PV(pv0), .HBLK(hblk0), .VBLK(vblk0),
    .HSYNC(hs0), .VSYNC(vs0), .IRQ(irq0), .FRAME(frame0)
  );

  segasys1_vtiming #(
    .HS_START(310), .V_TOTAL(16), .V_ACTIVE(10), .VS_START(12)
  ) u_dut1 (
    .VCLK(VCLK), .RESET(rst1), .PCE(pce1), .INTACK(ack1),
    .HOFS(hofs1), .VOFS(vofs1),
    .PH(ph1), .PV(pv1), .HBLK(hblk1), .VBLK(vblk1),
    .HSYNC(hs1), .VSYNC(vs1), .IRQ(irq1), .FRAME(frame1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge VCLK);
    #1;
  endtask

  task automatic adv(input int n);
    repeat (n) tick();
  endtask

  task automatic phase_a();
    pce0 = 1'b1;
    // line 0: every pixel
    for (int i = 1; i <= 320; i++) begin
      tick();
      check("a_ph", ph0, i % 320);
      check("a_pv", pv0, (i == 320) ? 1 : 0);
      check("a_hblk", hblk0, ((i % 320) >= 256) ? 1 : 0);
      check("a_hsync", hs0, ((i % 320) >= 280 && (i % 320) < 304) ? 1 : 0);
    end
    // offsets change mid-frame: this frame must not see them
    hofs0 = 4'h8;
    vofs0 = 4'h7;
    for (int l = 1; l < 260; l++) begin
      check("a_line_pv", pv0, l);
      check("a_line_ph", ph0, 0);
      check("a_vblk", vblk0, (l >= 224) ? 1 : 0);
      check("a_vsync", vs0, (l >= 236 && l <= 238) ? 1 : 0);
      check("a_irq", irq0, (l == 224) ? 1 : 0);
      adv(279);
      check("a_hs279", hs0, 0);
      tick();
      check("a_hs280", hs0, 1);
      adv(39);
      if (l == 224) check("a_irq_eol", irq0, 1);
      tick();
    end
    check("a_wrap_pv", pv0, 0);
    check("a_wrap_ph", ph0, 0);
    check("a_frame", frame0, 1);
    check("a_wrap_vblk", vblk0, 0);
    check("a_wrap_vsync", vs0, 0);
    check("a_wrap_irq", irq0, 0);
    // next frame: HSYNC shifted by -8 only when offsets are built in
    adv(271);
    check("a_f1_hs271", hs0, 0);
    tick();
    check("a_f1_hs272", hs0, OFS_EN);
    adv(23);
    check("a_f1_hs295", hs0, 1);
    tick();
    check("a_f1_hs296", hs0, !OFS_EN);
    adv(7);
    check("a_f1_hs303", hs0, !OFS_EN);
    tick();
    check("a_f1_hs304", hs0, 0);
    check("a_f1_ph304", ph0, 304);
    pce0 = 1'b0;
    adv(3);
    check("a_hold_ph", ph0, 304);
    check("a_hold_pv", pv0, 0);
    check("a_hold_frame", frame0, 1);
  endtask

  task automatic phase_b();
    pce1 = 1'b1;
    adv(5);
    hofs1 = 4'd7;
    vofs1 = 4'd7;
    adv(2875);
    check("b_pv9", pv1, 9);
    check("b_ph0", ph1, 0);
    check("b_irq_pre", irq1, 0);
    ack1 = 1'b1;
    tick();
    ack1 = 1'b0;
    check("b_ack_idle", irq1, 0);
    adv(318);
    check("b_irq_319", irq1, 0);
    tick();
    check("b_irq_set", irq1, 1);
    check("b_pv10", pv1, 10);
    check("b_vblk10", vblk1, 1);
    adv(10);
    check("b_irq_ph10", irq1, 1);
    ack1 = 1'b1;
    tick();
    ack1 = 1'b0;
    check("b_irq_acked", irq1, 0);
    adv(309);
    check("b_pv11", pv1, 11);
    check("b_irq_l11", irq1, 0);
    for (int l = 11; l < 16; l++) begin
      check("b_f0_pv", pv1, l);
      check("b_f0_vsync", vs1, (l >= 12 && l <= 14) ? 1 : 0);
      adv(320);
    end
    check("b_frame1", frame1, 1);
    check("b_f1_pv0", pv1, 0);
    check("b_f1_vs0", vs1, 0);
    check("b_f1_hs0", hs1, 1);
    adv(13);
    check("b_f1_hs13", hs1, 1);
    tick();
    check("b_f1_hs14", hs1, OFS_EN);
    adv(6);
    check("b_f1_hs20", hs1, OFS_EN);
    tick();
    check("b_f1_hs21", hs1, 0);
    adv(288);
    check("b_f1_hs309", hs1, 0);
    tick();
    check("b_f1_hs310", hs1, !OFS_EN);
    adv(6);
    check("b_f1_hs316", hs1, !OFS_EN);
    tick();
    check("b_f1_hs317", hs1, 1);
    adv(2);
    check("b_f1_hs319", hs1, 1);
    tick();
    for (int l = 1; l <= 9; l++) begin
      check("b_f1_pv", pv1, l);
      check("b_f1_vsync", vs1, (OFS_EN && l >= 3 && l <= 5) ? 1 : 0);
      if (l < 9) adv(320);
    end
    adv(319);
    ack1 = 1'b1;
    tick();
    ack1 = 1'b0;
    check("b_set_wins", irq1, 1);
    tick();
    check("b_irq_held", irq1, 1);
    check("b_ph1", ph1, 1);
    for (int k = 0; k < 3; k++) begin
      pce1 = 1'b0;
      adv(3);
      check("b_pce_hold", ph1, 1 + k);
      pce1 = 1'b1;
      tick();
      check("b_pce_step", ph1, 2 + k);
    end
    pce1 = 1'b0;
    ack1 = 1'b1;
    tick();
    ack1 = 1'b0;
    check("b_ack_nopce", irq1, 0);
    check("b_ph_nopce", ph1, 4);
    pce1 = 1'b1;
    adv(786);
    check("b_pre_rst_pv", pv1, 12);
    check("b_pre_rst_ph", ph1, 150);
    check("b_pre_rst_vblk", vblk1, 1);
    check("b_pre_rst_vs", vs1, !OFS_EN);
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    check("b_rst_ph", ph1, 0);
    check("b_rst_pv", pv1, 0);
    check("b_rst_frame", frame1, 0);
    check("b_rst_irq", irq1, 0);
    check("b_rst_hblk", hblk1, 0);
    check("b_rst_vblk", vblk1, 0);
    check("b_rst_hs", hs1, 0);
    check("b_rst_vs", vs1, 0);
    tick();
    check("b_run_ph", ph1, 1);
    check("b_run_pv", pv1, 0);
    check("b_run_hs1", hs1, 1);
    adv(13);
    check("b_run_hs14", hs1, 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst0 = 1'b1; pce0 = 1'b0; ack0 = 1'b0; hofs0 = 4'd0; vofs0 = 4'd0;
    rst1 = 1'b1; pce1 = 1'b0; ack1 = 1'b0; hofs1 = 4'd0; vofs1 = 4'd0;
    tick();
    tick();
    check("rst_ph", ph0, 0);
    check("rst_pv", pv0, 0);
    check("rst_frame", frame0, 0);
    check("rst_hblk", hblk0, 0);
    check("rst_vblk", vblk0, 0);
    check("rst_hsync", hs0, 0);
    check("rst_vsync", vs0, 0);
    check("rst_irq", irq0, 0);
    rst0 = 1'b0;
    rst1 = 1'b0;
    fork
      phase_a();
      phase_b();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/segasys1_vtiming.md
Name: segasys1_vtiming

Overview:
Master video timing generator for the System 1 video path. Produces the PH/PV raster counters, blanking and sync, and a frame counter, all consumed by the video block and the top-level video output. Also generates the vertical-blank CPU interrupt request, held until the CPU acknowledges it. All outputs are registered and advance on a single pixel-enable strobe.

Parameters:
H_TOTAL, 320, pixels per line (PH counts 0..H_TOTAL-1)
H_ACTIVE, 256, visible pixels; HBLK=1 for PH>=H_ACTIVE
HS_START, 280, first PH with HSYNC asserted (before offset)
HS_WIDTH, 24, HSYNC length in pixels
V_TOTAL, 260, lines per frame (PV counts 0..V_TOTAL-1)
V_ACTIVE, 224, visible lines; VBLK=1 for PV>=V_ACTIVE
VS_START, 236, first PV with VSYNC asserted (before offset)
VS_WIDTH, 3, VSYNC length in lines

Ports:
VCLK  in  1  clock; all state changes on the rising edge
RESET  in  1  synchronous reset, active-high
PCE  in  1  pixel clock enable; counters advance only when PCE=1
INTACK  in  1  CPU interrupt acknowledge; one-VCLK pulse
HOFS  in  4  signed HSYNC offset, -8..+7 pixels (optional feature)
VOFS  in  4  signed VSYNC offset, -8..+7 lines (optional feature)
PH  out  9  horizontal pixel counter
PV  out  9  vertical line counter
HBLK  out  1  horizontal blank
VBLK  out  1  vertical blank
HSYNC  out  1  horizontal sync, active-high
VSYNC  out  1  vertical sync, active-high
IRQ  out  1  vblank interrupt request, level, active-high
FRAME  out  8  frame counter

Behaviour:
- Reset (RESET=1 at a VCLK edge):
  - PH=0, PV=0, FRAME=0.
  - HBLK=0, VBLK=0, HSYNC=0, VSYNC=0, IRQ=0.
  - Latched offsets cleared to 0.
  - Reset has priority over PCE and INTACK.
  - Reset mid-frame restarts the raster at (0,0) on the next edge.
- Counting (PCE=1, no reset):
  - PH<=PH+1.
  - At PH==H_TOTAL-1: PH<=0 and PV advances.
  - At PV==V_TOTAL-1 with line wrap: PV<=0 and FRAME<=FRAME+1 (8-bit, wraps 255->0).
  - With PCE=0 all counters and outputs hold, except the INTACK clear of IRQ.
- Derived outputs are registered from the next counter values, so they always describe the PH/PV shown on the same cycle. Zero extra latency relative to PH/PV.
  - HBLK = PH>=H_ACTIVE.
  - VBLK = PV>=V_ACTIVE.
  - HSYNC = PH in [HS_START+hofs_l, HS_START+hofs_l+HS_WIDTH). Window computed modulo H_TOTAL, so a window crossing PH wrap remains contiguous.
  - VSYNC = PV in [VS_START+vofs_l, VS_START+vofs_l+VS_WIDTH), modulo V_TOTAL. VSYNC changes only together with PV.
- IRQ handshake:
  - Set on the PCE cycle entering PH==0, PV==V_ACTIVE (224 by default).
  - Cleared on INTACK=1, whether or not PCE is asserted.
  - Auto-cleared on entering PH==0, PV==V_ACTIVE+1 if not yet acknowledged.
  - If set and INTACK occur on the same edge, set wins and IRQ=1.
  - INTACK while IRQ=0 is ignored.
- Counter arithmetic is 9-bit unsigned. Offset sums use 10-bit signed intermediates reduced modulo the total.
- Parameter legality: HS_WIDTH<H_TOTAL, VS_WIDTH<V_TOTAL, H_TOTAL<=512, V_TOTAL<=512. Not checked in hardware.

Optional Feature:
SYS1_VTIMING_OFFSET_EN
- Defined:
  - HOFS/VOFS sign-extended and latched into hofs_l/vofs_l once per frame, on the PCE cycle where PV and PH both wrap to 0.
  - Mid-frame changes take effect from the next frame only.
- Undefined:
  - hofs_l=vofs_l=0 constant; HOFS/VOFS ignored.
  - Sync positions are exactly HS_START/VS_START.

Test Plan:
1. Reset, then PCE=1 continuously for 320 cycles -> PH counts 0..319 then 0; PV goes 0->1 on the wrap cycle; HBLK rises at PH=256; HSYNC high for PH 280..303.
2. Run 260x320 PCE cycles from reset -> PV wraps 259->0 with FRAME 0->1; VBLK high for PV 224..259; VSYNC high for PV 236..238.
3. Reach PV=224 PH=0, no INTACK -> IRQ=1 for the whole line 224 and 0 at PV=225 PH=0. Repeat with INTACK pulsed at PV=224 PH=10 -> IRQ=0 from the next edge.
4. INTACK asserted on the exact IRQ-set edge -> IRQ=1. PCE toggling 1-of-4 -> PH advances once per 4 VCLK; INTACK with PCE=0 still clears IRQ.
5. Assert RESET at PV=100 PH=150 for one cycle -> next outputs PH=0, PV=0, IRQ=0, FRAME=0, all sync/blank 0; counting resumes from 0.
6. Macro defined, HOFS=-8 and VOFS=+7 applied mid-frame -> current frame unchanged. Next frame: HSYNC PH 272..295, VSYNC PV 243..245. HOFS=+7 with HS_START=310 -> HSYNC PH 317..319 and 0..20 (wrap). Macro undefined -> timing identical to test 1 regardless of HOFS/VOFS.
